comm_responder: RTL and testbench

//  Far end of the 3-byte command link: receives frames {cmd, data[15:8], data[7:0]} over UART,

---
 rtl/comm_pkg.sv | 16 +
 rtl/comm_responder_if.sv | 16 +
 rtl/comm_responder_uart.sv | 113 +++++++++++
 rtl/comm_responder.sv | 106 ++++++++++
 tb/tb_comm_responder.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/comm_pkg.sv
// Framing definitions for the 3-byte command link, shared with the command master.
// Frame on the wire: cmd, data[15:8], data[7:0].
package comm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } rx_state_t;

    localparam int FRM_BYTES = 3;
    localparam int BYTE_CMD  = 0;
    localparam int BYTE_HI   = 1;
    localparam int BYTE_LO   = 2;

endpackage

// File: rtl/comm_responder_if.sv
// Consumer-side handshake of the command responder: decoded frame out, response byte in.
// slave = responder, master = the device logic consuming commands and issuing responses.
interface comm_responder_if;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    modport slave  (output cmd, data, cmd_rdy, resp_sent,
                    input  clr_cmd_rdy, resp, send_resp);
    modport master (input  cmd, data, cmd_rdy, resp_sent,
                    output clr_cmd_rdy, resp, send_resp);
endinterface

// File: rtl/comm_responder_uart.sv
// 8N1 UART transceiver, BAUD_DIV clk cycles per bit; rx_rdy held until clr_rx_rdy.
// Latency: rx_rdy ~9.5 bit times after start edge; tx_done pulses one cycle after the stop bit.
// Backpressure: trmt ignored while tx_busy; a new RX byte overwrites an unacknowledged one.
module comm_responder_uart #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx_busy
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

    logic          rx_s1, rx_s2, rx_busy;
    logic [3:0]    rx_bit;
    logic [CW-1:0] rx_cnt;
    logic [7:0]    rx_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    // Bit 0 is the start bit (re-checked mid-bit to reject glitches), 1..8 data, 9 stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy <= 1'b0;
            rx_bit  <= 4'd0;
            rx_cnt  <= '0;
            rx_sh   <= 8'h00;
            rx_data <= 8'h00;
            rx_rdy  <= 1'b0;
        end else begin
            if (clr_rx_rdy)
                rx_rdy <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_bit  <= 4'd0;
                    rx_cnt  <= HALF;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - CW'(1);
            end else begin
                rx_cnt <= FULL;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    if (rx_s2)
                        rx_busy <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                    if (rx_s2) begin
                        rx_data <= rx_sh;
                        rx_rdy  <= 1'b1;
                    end
                end else begin
                    rx_sh <= {rx_s2, rx_sh[7:1]};
                end
            end
        end
    end

    logic [9:0]    tx_sh;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh   <= '1;
            tx_bit  <= 4'd0;
            tx_cnt  <= '0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (trmt && !tx_busy) begin
                tx_sh   <= {1'b1, tx_data, 1'b0};
                tx_bit  <= 4'd0;
                tx_cnt  <= FULL;
                tx_busy <= 1'b1;
            end else if (tx_busy) begin
                if (tx_cnt != '0) begin
                    tx_cnt <= tx_cnt - CW'(1);
                end else begin
                    tx_cnt <= FULL;
                    tx_sh  <= {1'b1, tx_sh[9:1]};
                    tx_bit <= tx_bit + 4'd1;
                    if (tx_bit == 4'd9) begin
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign tx = tx_sh[0];

endmodule

// File: rtl/comm_responder.sv
// Command link far end: assembles {cmd,data_hi,data_lo} frames, sends 1-byte responses.
// Latency: cmd_rdy one cycle after the 3rd byte is ready; optional inter-byte timeout via COMM_RESP_TIMEOUT_EN.
// Backpressure: none on RX (consumer must keep up); send_resp ignored while a response is shifting.
module comm_responder
    import comm_pkg::*;
#(
    parameter int TO_W        = 20,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int BAUD_DIV    = 434
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RX,
    output logic             TX,
    comm_responder_if.slave  bus
);
    logic [7:0] rx_data;
    logic       rx_rdy, clr_rx_rdy;
    logic       trmt, tx_done, tx_busy;
    logic       to_hit;
    rx_state_t  state;
    logic [7:0] cmd_hold, data_hi;

    // Every state consumes the byte it sees, so the ack is simply the ready flag.
    assign clr_rx_rdy = rx_rdy;
    assign trmt       = bus.send_resp & ~tx_busy;

    comm_responder_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (RX),
        .tx         (TX),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy),
        .trmt       (trmt),
        .tx_data    (bus.resp),
        .tx_done    (tx_done),
        .tx_busy    (tx_busy)
    );

`ifdef COMM_RESP_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state == IDLE || rx_rdy || to_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TO_W'(1);
    end

    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd_hold <= 8'h00;
            data_hi  <= 8'h00;
            bus.cmd  <= 8'h00;
            bus.data <= 16'h0000;
        end else if (rx_rdy) begin
            unique case (state)
                IDLE: begin
                    cmd_hold <= rx_data;
                    state    <= WAIT_HI;
                end
                WAIT_HI: begin
                    data_hi <= rx_data;
                    state   <= WAIT_LO;
                end
                WAIT_LO: begin
                    bus.cmd  <= cmd_hold;
                    bus.data <= {data_hi, rx_data};
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end else if (to_hit) begin
            state <= IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.cmd_rdy <= 1'b0;
        else if (rx_rdy && state == WAIT_LO)
            bus.cmd_rdy <= 1'b1;
        else if ((rx_rdy && state == IDLE) || bus.clr_cmd_rdy)
            bus.cmd_rdy <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.resp_sent <= 1'b0;
        else if (trmt)
            bus.resp_sent <= 1'b0;
        else if (tx_done)
            bus.resp_sent <= 1'b1;
    end

endmodule

// File: tb/tb_comm_responder.sv
// Bench for comm_responder: bit-banged master on RX, serial monitor on TX, byte-queue reference model.
module tb_comm_responder;
    import comm_pkg::*;

    localparam int DIV = 16;
    localparam int TMO = 5000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx_line = 1'b1;
    logic tx_line;

    comm_responder_if bus_if();

    comm_responder #(.TO_W(20), .TIMEOUT_CYC(TMO), .BAUD_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (rx_line),
        .TX    (tx_line),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sent_cnt = 0;
    logic [7:0] rxq[$];

    // Reference model: bytes accumulate until a frame's worth has arrived.
    logic [7:0]  pend[$];
    logic [7:0]  m_cmd;
    logic [15:0] m_data;
    logic        m_rdy;

    function automatic void model_reset();
        pend.delete();
        m_cmd  = 8'h00;
        m_data = 16'h0000;
        m_rdy  = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        pend.push_back(b);
        if (pend.size() == 1)
            m_rdy = 1'b0;
        if (pend.size() == FRM_BYTES) begin
            m_cmd  = pend[BYTE_CMD];
            m_data = {pend[BYTE_HI], pend[BYTE_LO]};
            m_rdy  = 1'b1;
            pend.delete();
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string nm);
        chk({nm, "_cmd"},  {24'h0, bus_if.cmd},     {24'h0, m_cmd});
        chk({nm, "_data"}, {16'h0, bus_if.data},    {16'h0, m_data});
        chk({nm, "_rdy"},  {31'h0, bus_if.cmd_rdy}, {31'h0, m_rdy});
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_line = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_mbyte(input logic [7:0] b);
        send_byte(b);
        model_byte(b);
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [15:0] d);
        send_mbyte(c);
        send_mbyte(d[15:8]);
        send_mbyte(d[7:0]);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus_if.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus_if.clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
    endtask

    task automatic send_resp_task(input logic [7:0] r);
        @(negedge clk);
        bus_if.resp = r;
        bus_if.send_resp = 1'b1;
        @(negedge clk);
        bus_if.send_resp = 1'b0;
    endtask

    task automatic wait_sent(input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20 * DIV && !ok; i++) begin
            @(negedge clk);
            if (bus_if.resp_sent) ok = 1'b1;
        end
        chk(nm, {31'h0, ok}, 32'd1);
    endtask

    task automatic check_rx(input string nm, input logic [7:0] exp);
        logic [8:0] got;
        for (int i = 0; i < 12 * DIV && rxq.size() == 0; i++)
            @(negedge clk);
        got = (rxq.size() != 0) ? {1'b0, rxq.pop_front()} : 9'h100;
        chk(nm, {23'h0, got}, {24'h0, exp});
    endtask

    // Serial monitor on the response line.
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge tx_line);
            repeat (DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clk);
                b[i] = tx_line;
            end
            rxq.push_back(b);
            repeat (DIV) @(negedge clk);
        end
    end

    always @(posedge bus_if.resp_sent) sent_cnt++;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  c;
        logic [15:0] d;
        logic        clr;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_data;
        logic        exp_rdy_after;
    } vec_t;

    vec_t vec[4];

    initial begin : main
        int s0;
        logic [7:0]  rc;
        logic [15:0] rd;

        vec[0] = '{8'hA5, 16'h1234, 1'b0, 8'hA5, 16'h1234, 1'b1};
        vec[1] = '{8'h00, 16'h0000, 1'b1, 8'h00, 16'h0000, 1'b0};
        vec[2] = '{8'hFF, 16'hFFFF, 1'b1, 8'hFF, 16'hFFFF, 1'b0};
        vec[3] = '{8'h3C, 16'h81C3, 1'b0, 8'h3C, 16'h81C3, 1'b1};

        bus_if.clr_cmd_rdy = 1'b0;
        bus_if.resp        = 8'h00;
        bus_if.send_resp   = 1'b0;
        model_reset();

        repeat (5) @(negedge clk);
        chk("rst_tx",        {31'h0, tx_line},          32'd1);
        chk("rst_cmd",       {24'h0, bus_if.cmd},       32'h0);
        chk("rst_data",      {16'h0, bus_if.data},      32'h0);
        chk("rst_cmd_rdy",   {31'h0, bus_if.cmd_rdy},   32'd0);
        chk("rst_resp_sent", {31'h0, bus_if.resp_sent}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        pulse_clr();
        chk("clr_when_idle", {31'h0, bus_if.cmd_rdy}, 32'd0);
        rxq.delete();

        // Table-driven frames with optional acknowledge
        for (int i = 0; i < 4; i++) begin
            send_frame(vec[i].c, vec[i].d);
            chk($sformatf("tbl%0d_cmd", i),  {24'h0, bus_if.cmd},     {24'h0, vec[i].exp_cmd});
            chk($sformatf("tbl%0d_data", i), {16'h0, bus_if.data},    {16'h0, vec[i].exp_data});
            chk($sformatf("tbl%0d_rdy", i),  {31'h0, bus_if.cmd_rdy}, 32'd1);
            if (vec[i].clr) pulse_clr();
            else repeat (50) @(negedge clk);
            chk($sformatf("tbl%0d_rdy_after", i), {31'h0, bus_if.cmd_rdy}, {31'h0, vec[i].exp_rdy_after});
            chk($sformatf("tbl%0d_cmd_hold", i),  {24'h0, bus_if.cmd},     {24'h0, vec[i].exp_cmd});
        end

        // Back-to-back frames without acknowledge; old frame stays visible until completion
        send_frame(8'h01, 16'h0203);
        chk_model("b2b1");
        send_mbyte(8'h04);
        chk("b2b_rdy_drop", {31'h0, bus_if.cmd_rdy}, 32'd0);
        chk("b2b_cmd_hold1", {24'h0, bus_if.cmd}, 32'h01);
        send_mbyte(8'h05);
        chk("b2b_data_hold2", {16'h0, bus_if.data}, 32'h0203);
        send_mbyte(8'h06);
        chk_model("b2b2");
        chk("b2b_final_data", {16'h0, bus_if.data}, 32'h0506);

        // Single response
        send_resp_task(8'h5A);
        chk("resp_start_low", {31'h0, bus_if.resp_sent}, 32'd0);
        repeat (5 * DIV) @(negedge clk);
        chk("resp_mid_low", {31'h0, bus_if.resp_sent}, 32'd0);
        wait_sent("resp_done");
        check_rx("resp_byte", 8'h5A);

        // Second send while shifting is ignored
        s0 = sent_cnt;
        send_resp_task(8'h01);
        repeat (3 * DIV) @(negedge clk);
        send_resp_task(8'h02);
        wait_sent("ign_done");
        repeat (12 * DIV) @(negedge clk);
        chk("ign_count", rxq.size(), 32'd1);
        check_rx("ign_byte", 8'h01);
        chk("ign_sent_once", sent_cnt - s0, 32'd1);

        // Send in the very cycle tx_done fires: accepted, resp_sent stays low
        @(negedge clk);
        bus_if.resp = 8'hC3;
        bus_if.send_resp = 1'b1;
        @(negedge clk);
        bus_if.send_resp = 1'b0;
        repeat (10 * DIV) @(negedge clk);
        bus_if.resp = 8'h3C;
        bus_if.send_resp = 1'b1;
        @(negedge clk);
        bus_if.send_resp = 1'b0;
        chk("coll_sent_low", {31'h0, bus_if.resp_sent}, 32'd0);
        wait_sent("coll_done");
        check_rx("coll_byte1", 8'hC3);
        check_rx("coll_byte2", 8'h3C);

        // Reset mid-frame with a response in flight
        send_mbyte(8'hAA);
        fork
            send_byte(8'hBB);
            begin
                repeat (2 * DIV) @(negedge clk);
                send_resp_task(8'h00);
            end
        join
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mrst_tx", {31'h0, tx_line}, 32'd1);
        chk("mrst_resp_sent", {31'h0, bus_if.resp_sent}, 32'd0);
        chk_model("mrst");
        repeat (12 * DIV) @(negedge clk);
        rxq.delete();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h11, 16'h2233);
        chk_model("post_rst");

        // Randomized frames, acknowledges and responses
        for (int k = 0; k < 16; k++) begin
            rc = 8'($urandom);
            rd = 16'($urandom);
            send_frame(rc, rd);
            chk_model($sformatf("rnd%0d", k));
            if ($urandom_range(1, 0) == 1) begin
                pulse_clr();
                chk($sformatf("rnd%0d_clr", k), {31'h0, bus_if.cmd_rdy}, {31'h0, m_rdy});
            end
            if ($urandom_range(3, 0) == 0) begin
                rc = 8'($urandom);
                send_resp_task(rc);
                wait_sent($sformatf("rnd%0d_sent", k));
                check_rx($sformatf("rnd%0d_resp", k), rc);
            end
        end

        // Stray byte followed by a long gap, then a proper frame
        send_mbyte(8'hFF);
        repeat (6000) @(negedge clk);
`ifdef COMM_RESP_TIMEOUT_EN
        pend.delete();
`endif
        send_frame(8'h11, 16'h2233);
        chk_model("gap");
`ifdef COMM_RESP_TIMEOUT_EN
        chk("gap_cmd_fixed", {24'h0, bus_if.cmd}, 32'h11);
`else
        chk("gap_cmd_fixed", {24'h0, bus_if.cmd}, 32'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
